// File: rtl/game_pkg.sv
// Shared definitions for the game front end: move encoding, sequencer modes
// and the built-in winning autoplay script.
package game_pkg;

    localparam int unsigned MOVE_W  = 6;
    localparam int unsigned COUNT_W = 8;

    // Bit positions inside a move command
    localparam int unsigned MOVE_UP    = 5;
    localparam int unsigned MOVE_DOWN  = 4;
    localparam int unsigned MOVE_NORTH = 3;
    localparam int unsigned MOVE_EAST  = 2;
    localparam int unsigned MOVE_SOUTH = 1;
    localparam int unsigned MOVE_WEST  = 0;

    typedef logic [MOVE_W-1:0] move_t;

    typedef enum logic [1:0] {
        MANUAL   = 2'd0,
        AUTO_RUN = 2'd1,
        AUTO_FIN = 2'd2
    } seq_mode_t;

    localparam int unsigned SCRIPT_LEN = 9;

    // start -> elevator B -> weapon shop -> B -> A -> lab -> A -> B -> C -> win
    localparam move_t WIN_SCRIPT [SCRIPT_LEN] = '{
        6'b100000,  // UP
        6'b000001,  // WEST
        6'b000100,  // EAST
        6'b010000,  // DOWN
        6'b001000,  // NORTH
        6'b000010,  // SOUTH
        6'b100000,  // UP
        6'b100000,  // UP
        6'b000000   // none
    };

    // True when more than one move bit is set (clearing the lowest set bit leaves something)
    function automatic logic multi_move(input move_t m);
        return (m & (m - move_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Step button front end: 2-flop synchronizer and debounce counter.
// Ports:
//   clock, reset : sole clock, synchronous active-high reset
//   key_n        : raw active-low step button (asynchronous)
//   press        : one-cycle pulse when the debounced level falls 1->0
module step_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Level changes only after DEBOUNCE_CYCLES consecutive differing samples;
    // any agreeing sample restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    press <= ~sync[1];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/game_input_sequencer.sv
// Player-side front end: turns the step button and move switches (or the
// built-in autoplay script) into a held one-hot move and a one-cycle step strobe.
// Ports:
//   CLOCK, RESET : sole clock, synchronous active-high reset
//   KEY_STEP_N   : raw step button, active-low
//   SW_MOVE      : raw move switches {U,D,N,E,S,W}
//   SW_AUTO      : raw autoplay mode switch
//   MOVE_OUT     : held move command
//   STEP         : one-cycle strobe, MOVE_OUT valid while high
//   ILLEGAL      : last manual step had more than one move bit
//   AUTO_DONE    : autoplay script fully issued
//   STEP_COUNT   : saturating count of steps since reset
module game_input_sequencer
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_PERIOD     = 32
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               KEY_STEP_N,
    input  logic [MOVE_W-1:0]  SW_MOVE,
    input  logic               SW_AUTO,
    output logic [MOVE_W-1:0]  MOVE_OUT,
    output logic               STEP,
    output logic               ILLEGAL,
    output logic               AUTO_DONE,
    output logic [COUNT_W-1:0] STEP_COUNT
);

    localparam int unsigned PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int unsigned IW = $clog2(SCRIPT_LEN);

    seq_mode_t    state_q, state_d;
    move_t        move_s1, move_s2;
    logic         auto_s1, auto_s2;
    logic         press;
    logic [PW-1:0] per_q, per_d;
    logic [IW-1:0] idx_q, idx_d;
    move_t        move_d;
    logic         step_d, illegal_d, done_d;
    logic [COUNT_W-1:0] count_d;
    logic         tc_c;

    step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock (CLOCK),
        .reset (RESET),
        .key_n (KEY_STEP_N),
        .press (press)
    );

    assign tc_c = (per_q == PW'(AUTO_PERIOD - 1));

    // State register plus synchronizers and registered outputs
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= MANUAL;
            move_s1    <= '0;
            move_s2    <= '0;
            auto_s1    <= 1'b0;
            auto_s2    <= 1'b0;
            per_q      <= '0;
            idx_q      <= '0;
            MOVE_OUT   <= '0;
            STEP       <= 1'b0;
            ILLEGAL    <= 1'b0;
            AUTO_DONE  <= 1'b0;
            STEP_COUNT <= '0;
        end else begin
            state_q    <= state_d;
            move_s1    <= SW_MOVE;
            move_s2    <= move_s1;
            auto_s1    <= SW_AUTO;
            auto_s2    <= auto_s1;
            per_q      <= per_d;
            idx_q      <= idx_d;
            MOVE_OUT   <= move_d;
            STEP       <= step_d;
            ILLEGAL    <= illegal_d;
            AUTO_DONE  <= done_d;
            STEP_COUNT <= count_d;
        end
    end

    // Mode transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            MANUAL:   if (auto_s2) state_d = AUTO_RUN;
            AUTO_RUN: begin
                if (!auto_s2)                                  state_d = MANUAL;
                else if (tc_c && idx_q == IW'(SCRIPT_LEN - 1)) state_d = AUTO_FIN;
            end
            AUTO_FIN: if (!auto_s2) state_d = MANUAL;
            default:  state_d = MANUAL;
        endcase
    end

    // Next values of counters and output registers; a mode change in either
    // direction swallows any press or terminal count in the same cycle.
    always_comb begin
        step_d    = 1'b0;
        move_d    = MOVE_OUT;
        illegal_d = ILLEGAL;
        idx_d     = idx_q;
        per_d     = per_q;
        done_d    = (state_d == AUTO_FIN);
        count_d   = STEP_COUNT;
        case (state_q)
            MANUAL: begin
                if (auto_s2) begin
                    idx_d = '0;
                    per_d = '0;
                end else if (press) begin
                    step_d    = 1'b1;
                    illegal_d = multi_move(move_s2);
                    move_d    = multi_move(move_s2) ? '0 : move_s2;
                end
            end
            AUTO_RUN: begin
                if (!auto_s2) begin
                    idx_d = '0;
                end else if (tc_c) begin
                    per_d     = '0;
                    step_d    = 1'b1;
                    move_d    = WIN_SCRIPT[idx_q];
                    illegal_d = 1'b0;
                    idx_d     = idx_q + IW'(1);
                end else begin
                    per_d = per_q + PW'(1);
                end
            end
            AUTO_FIN: if (!auto_s2) idx_d = '0;
            default: ;
        endcase
        if (step_d && STEP_COUNT != '1) count_d = STEP_COUNT + COUNT_W'(1);
    end

endmodule

// File: tb/tb_game_input_sequencer.sv
// Scoreboard bench: stimulus pushes expected steps (edge, move, illegal, count),
// a negedge monitor pops and compares whenever STEP is high.
module tb_game_input_sequencer;

    localparam int D = 16;
    localparam int P = 32;

    logic       CLOCK;
    logic       RESET;
    logic       KEY_STEP_N;
    logic [5:0] SW_MOVE;
    logic       SW_AUTO;
    logic [5:0] MOVE_OUT;
    logic       STEP;
    logic       ILLEGAL;
    logic       AUTO_DONE;
    logic [7:0] STEP_COUNT;

    game_input_sequencer #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .KEY_STEP_N (KEY_STEP_N),
        .SW_MOVE    (SW_MOVE),
        .SW_AUTO    (SW_AUTO),
        .MOVE_OUT   (MOVE_OUT),
        .STEP       (STEP),
        .ILLEGAL    (ILLEGAL),
        .AUTO_DONE  (AUTO_DONE),
        .STEP_COUNT (STEP_COUNT)
    );

    typedef struct {
        int         at_edge;
        logic [5:0] mv;
        logic       ill;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_count = 0;
    logic prev_step = 1'b0;
    logic [5:0] script [9] = '{6'b100000, 6'b000001, 6'b000100, 6'b010000,
                               6'b001000, 6'b000010, 6'b100000, 6'b100000, 6'b000000};

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every STEP must match the head of the scoreboard
    always @(negedge CLOCK) begin
        if (STEP) begin
            n_cmp++;
            if (prev_step) begin
                n_bad++;
                $display("FAIL back_to_back_step: STEP high two cycles (edge %0d)", cyc);
            end
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_step: got STEP move=%b at edge %0d, expected none", MOVE_OUT, cyc);
            end else begin
                e = sb.pop_front();
                chk("step_edge", cyc, e.at_edge);
                chk("step_move", int'(MOVE_OUT), int'(e.mv));
                chk("step_illegal", int'(ILLEGAL), int'(e.ill));
                chk("step_count", int'(STEP_COUNT), e.cnt);
            end
        end
        prev_step = STEP;
    end

    function automatic int sat_inc(input int c);
        return (c < 255) ? c + 1 : 255;
    endfunction

    // Manual press held well past debounce, then released past debounce.
    // Button first sampled on the next edge n; STEP is registered on edge n+2+D.
    task automatic press_step(input logic [5:0] mv, input bit expect_step);
        exp_t x;
        SW_MOVE    = mv;
        KEY_STEP_N = 1'b0;
        if (expect_step) begin
            exp_count = sat_inc(exp_count);
            x.at_edge = cyc + 3 + D;
            x.ill     = ($countones(mv) > 1);
            x.mv      = x.ill ? 6'b000000 : mv;
            x.cnt     = exp_count;
            sb.push_back(x);
        end
        repeat (D + 6) @(negedge CLOCK);
        KEY_STEP_N = 1'b1;
        repeat (D + 6) @(negedge CLOCK);
    endtask

    // Raise SW_AUTO and queue the first n script entries
    task automatic start_auto(input int n);
        exp_t x;
        int   m;
        m = cyc;
        SW_AUTO = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_count = sat_inc(exp_count);
            x.at_edge = m + 3 + P * (k + 1);
            x.mv      = script[k];
            x.ill     = 1'b0;
            x.cnt     = exp_count;
            sb.push_back(x);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_move"},  int'(MOVE_OUT), 0);
        chk({tag, "_step"},  int'(STEP), 0);
        chk({tag, "_ill"},   int'(ILLEGAL), 0);
        chk({tag, "_done"},  int'(AUTO_DONE), 0);
        chk({tag, "_count"}, int'(STEP_COUNT), 0);
    endtask

    task automatic do_reset();
        RESET   = 1'b1;
        SW_AUTO = 1'b0;
        @(negedge CLOCK);
        RESET     = 1'b0;
        exp_count = 0;
        check_all_zero("reset");
    endtask

    initial begin
        RESET      = 1'b1;
        KEY_STEP_N = 1'b1;
        SW_MOVE    = 6'b000000;
        SW_AUTO    = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        check_all_zero("por");

        // Button low from edge 10 -> STEP registered at edge 28
        repeat (6) @(negedge CLOCK);
        press_step(6'b001000, 1'b1);
        chk("first_count", int'(STEP_COUNT), 1);

        // Short glitch is filtered, the long press yields one step
        KEY_STEP_N = 1'b0;
        repeat (10) @(negedge CLOCK);
        KEY_STEP_N = 1'b1;
        repeat (6) @(negedge CLOCK);
        press_step(6'b000100, 1'b1);

        // Illegal combo, then a legal one clears ILLEGAL
        press_step(6'b110000, 1'b1);
        press_step(6'b000001, 1'b1);
        chk("held_move", int'(MOVE_OUT), 6'b000001);
        chk("held_ill", int'(ILLEGAL), 0);

        // Full autoplay from a fresh reset
        do_reset();
        start_auto(9);
        repeat (3 + 9 * P + 4) @(negedge CLOCK);
        chk("auto_done", int'(AUTO_DONE), 1);
        chk("auto_count", int'(STEP_COUNT), 9);
        chk("auto_last_move", int'(MOVE_OUT), 0);
        press_step(6'b001000, 1'b0);
        chk("fin_count", int'(STEP_COUNT), 9);
        SW_AUTO = 1'b0;
        repeat (4) @(negedge CLOCK);
        chk("exit_done", int'(AUTO_DONE), 0);

        // Drop autoplay after step 4, then restart from UP
        start_auto(4);
        repeat (3 + 4 * P + 2) @(negedge CLOCK);
        SW_AUTO = 1'b0;
        repeat (3 * P) @(negedge CLOCK);
        chk("drop_count", int'(STEP_COUNT), 13);
        start_auto(5);
        repeat (3 + 5 * P + 2) @(negedge CLOCK);

        // Reset mid-script, then saturate the counter manually
        do_reset();
        repeat (3) @(negedge CLOCK);
        chk("post_reset_done", int'(AUTO_DONE), 0);
        for (int i = 0; i < 300; i++) press_step(6'b000001, 1'b1);
        chk("sat_count", int'(STEP_COUNT), 255);

        repeat (10) @(negedge CLOCK);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_input_sequencer.md
# game_input_sequencer

Player-side front end for the game FSMs. Converts the raw step button and move switches into a registered one-hot move command and a one-cycle step strobe; the location, elevator and weapon FSMs advance only on that strobe. Also has an autoplay mode that replays the built-in winning script. Sits between the board pins and the game FSMs, in the direction opposite to the display decoders.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before the button level is accepted (board build: 1_000_000)
- AUTO_PERIOD, 32, cycles between autoplay steps
- SCRIPT_LEN, 9, autoplay script entries
- CLOCK  in  1  sole clock
- RESET  in  1  synchronous, active-high
- KEY_STEP_N  in  1  raw step button, active-low, asynchronous
- SW_MOVE  in  6  raw move switches {UP, DOWN, NORTH, EAST, SOUTH, WEST}, bit 5 = UP, bit 0 = WEST
- SW_AUTO  in  1  raw autoplay mode switch
- MOVE_OUT  out  6  held move command, same bit order as SW_MOVE
- STEP  out  1  one-cycle strobe; MOVE_OUT is valid whenever STEP = 1
- ILLEGAL  out  1  last manual step had more than one move bit set
- AUTO_DONE  out  1  autoplay script fully issued
- STEP_COUNT  out  8  steps issued since reset, saturating

## Operation
- Synchronizers: 2 flops each on KEY_STEP_N (reset 1), SW_MOVE (reset 0) and SW_AUTO (reset 0).
- Debounce: counter runs while the synchronized button differs from the debounced level and clears when they match. At DEBOUNCE_CYCLES the debounced level takes the new value. Debounced level resets to 1 (released).
- Press event: a 1->0 transition of the debounced level. Release events do nothing.
- Modes: MANUAL (reset), AUTO_RUN, AUTO_FIN.
- MANUAL -> AUTO_RUN when synchronized SW_AUTO = 1. On entry, clear the script index and the period counter.
- AUTO_RUN / AUTO_FIN -> MANUAL when synchronized SW_AUTO = 0. On exit, clear the index. No step is issued in the transition cycle.
- MANUAL press: sample synchronized SW_MOVE.
  - Popcount <= 1: MOVE_OUT = sample, ILLEGAL = 0.
  - Popcount >= 2: MOVE_OUT = 0, ILLEGAL = 1.
  - In both cases STEP = 1 for one cycle.
- AUTO_RUN: the period counter counts 0..AUTO_PERIOD-1. At terminal count:
  - STEP = 1 and MOVE_OUT = script[index]; ILLEGAL is cleared.
  - index increments.
  - After issuing script[SCRIPT_LEN-1], go to AUTO_FIN.
- AUTO_FIN: AUTO_DONE = 1. No further steps are issued, and the button is ignored.
- The button is ignored in AUTO_RUN.
- Script, one-hot {U,D,N,E,S,W}: UP, WEST, EAST, DOWN, NORTH, SOUTH, UP, UP, none (6'b000000).
  - Drives the game start -> elevator B -> weapon shop -> B -> A -> lab -> A -> B -> C -> win.
- MOVE_OUT and ILLEGAL hold between steps.
- STEP_COUNT increments on every STEP and saturates at 255.
- Reset values: MOVE_OUT = 0, STEP = 0, ILLEGAL = 0, AUTO_DONE = 0, STEP_COUNT = 0, mode MANUAL, index 0.

## Timing
- All outputs are registered.
- Manual latency: raw KEY_STEP_N is held low and first sampled at edge n.
  - Debounced level falls at edge n+1+DEBOUNCE_CYCLES.
  - STEP is high for exactly the cycle after edge n+2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no STEP.
- Holding the button produces exactly one STEP. A new STEP requires a debounced release followed by a debounced press.
- SW_MOVE is sampled in the same cycle as the press event, i.e. 2 cycles of synchronizer delay relative to the pins.
- Autoplay: the first STEP comes AUTO_PERIOD cycles after the cycle in which AUTO_RUN is entered. Subsequent STEPs are exactly AUTO_PERIOD apart.
- Simultaneous events:
  - A press event in the same cycle as MANUAL -> AUTO_RUN is discarded.
  - An autoplay terminal count in the same cycle as SW_AUTO falling is discarded.
- RESET mid-debounce or mid-script clears counters, index and outputs on the next edge. After reset, the button must pass a full debounce before a STEP is issued.
- STEP is never high in two consecutive cycles.

## Structure
- Shared package game_pkg holds:
  - MOVE_* bit-index constants and move_t (logic [5:0]).
  - Mode enum seq_mode_t {MANUAL, AUTO_RUN, AUTO_FIN}.
  - Constant array WIN_SCRIPT[SCRIPT_LEN] of move_t.
- Sub-module step_debounce (parameter DEBOUNCE_CYCLES): synchronizer plus debounce counter; outputs a one-cycle press pulse.
- The top of this block contains the mode FSM, the period counter, the index, the output registers and the popcount check.

## Test plan
- Reset with the button released and DEBOUNCE_CYCLES = 16 -> all outputs 0. Then hold the button low from edge 10 with SW_MOVE = 6'b001000 -> STEP only in the cycle after edge 28, MOVE_OUT = 6'b001000, STEP_COUNT = 1.
- 10-cycle low glitch, then 40 cycles low -> exactly one STEP. STEP latency is measured from the start of the 40-cycle low period.
- SW_MOVE = 6'b110000 at press -> STEP = 1, MOVE_OUT = 0, ILLEGAL = 1. Next press with 6'b000001 -> ILLEGAL = 0, MOVE_OUT = 6'b000001.
- SW_AUTO = 1 with AUTO_PERIOD = 32 -> 9 STEPs spaced 32 cycles apart, MOVE_OUT sequence 100000, 000001, 000100, 010000, 001000, 000010, 100000, 100000, 000000. Then AUTO_DONE = 1 and STEP_COUNT = 9. Button presses in AUTO_FIN produce no STEP.
- SW_AUTO dropped after the 4th autoplay step -> mode MANUAL, no further steps. Raising it again restarts the script at UP.
- RESET asserted mid-script (after step 5) -> next edge: all outputs 0, mode MANUAL, STEP_COUNT = 0. 300 manual presses -> STEP_COUNT = 255.
